// File: rtl/en_colmix_keyadd_serial_if.sv
// ---------------------------------------------------------------------------
// en_colmix_keyadd_serial_if
// Handshake and data bundle for the column-serial MixColumns/AddRoundKey
// block.
//   Upstream   : iValid, oReady, iBlockIn[127:0], iKeyValue[127:0], iLastRound
//   Downstream : oValid, iReady, oBlockout[127:0]
// Column layout on all 128-bit buses: column 0 = [127:96] ... column 3 = [31:0].
// The slave modport is the block's view; the master modport is the
// environment's view (drives the inputs, observes the outputs).
// ---------------------------------------------------------------------------
interface en_colmix_keyadd_serial_if;
  logic         iValid;
  logic         oReady;
  logic [127:0] iBlockIn;
  logic [127:0] iKeyValue;
  logic         iLastRound;
  logic         oValid;
  logic         iReady;
  logic [127:0] oBlockout;

  modport slave (
    input  iValid,
    input  iBlockIn,
    input  iKeyValue,
    input  iLastRound,
    input  iReady,
    output oReady,
    output oValid,
    output oBlockout
  );

  modport master (
    output iValid,
    output iBlockIn,
    output iKeyValue,
    output iLastRound,
    output iReady,
    input  oReady,
    input  oValid,
    input  oBlockout
  );
endinterface

// File: rtl/en_colmix_keyadd_serial.sv
// ---------------------------------------------------------------------------
// en_colmix_keyadd_serial
// AES-128 MixColumns followed by AddRoundKey (out = MixColumns(in) ^ key),
// or AddRoundKey alone when the latched last-round flag is set.
// A single 32-bit column datapath is reused for the four columns, one column
// per clock, so a block takes four cycles after it is accepted.
//
// Ports:
//   clk    : clock, rising edge active
//   rst_n  : asynchronous reset, active low
//   bus    : en_colmix_keyadd_serial_if.slave
//            iValid/oReady + iBlockIn/iKeyValue/iLastRound  (input side)
//            oValid/iReady + oBlockout                      (output side)
// ---------------------------------------------------------------------------
module en_colmix_keyadd_serial (
  input  logic                           clk,
  input  logic                           rst_n,
  en_colmix_keyadd_serial_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic         last_q, last_d;
  logic [127:0] out_q, out_d;
  logic         rdyEn_q;

  logic         accept;
  logic [31:0]  colIn;
  logic [31:0]  colKey;
  logic [31:0]  colMix;
  logic [31:0]  colRes;

  // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

  // One MixColumns column; byte a0 sits in the top byte of the word.
  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ mul3(a1) ^ a2        ^ a3;
    b1 = a0        ^ xtime(a1) ^ mul3(a2) ^ a3;
    b2 = a0        ^ a1        ^ xtime(a2) ^ mul3(a3);
    b3 = mul3(a0)  ^ a1        ^ a2        ^ xtime(a3);
    mixColumn = {b0, b1, b2, b3};
  endfunction

  // Pick the column the counter points at from the latched block and key.
  always_comb begin
    colIn  = blk_q[127:96];
    colKey = key_q[127:96];
    case (cnt_q)
      2'd0: begin colIn = blk_q[127:96]; colKey = key_q[127:96]; end
      2'd1: begin colIn = blk_q[95:64];  colKey = key_q[95:64];  end
      2'd2: begin colIn = blk_q[63:32];  colKey = key_q[63:32];  end
      2'd3: begin colIn = blk_q[31:0];   colKey = key_q[31:0];   end
      default: begin colIn = blk_q[127:96]; colKey = key_q[127:96]; end
    endcase
  end

  // The shared column datapath; the final round bypasses the mix.
  always_comb begin
    colMix = mixColumn(colIn);
    colRes = (last_q ? colIn : colMix) ^ colKey;
  end

  // Acceptance is held off until one edge after reset release so that the
  // ready output stays low while reset is applied.
  assign accept = (state_q == IDLE) && rdyEn_q && bus.iValid;

  // Next-state logic: latch on accept, write one column per BUSY cycle,
  // hold the finished block in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    key_d   = key_q;
    last_d  = last_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          blk_d   = bus.iBlockIn;
          key_d   = bus.iKeyValue;
          last_d  = bus.iLastRound;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (cnt_q)
          2'd0: out_d[127:96] = colRes;
          2'd1: out_d[95:64]  = colRes;
          2'd2: out_d[63:32]  = colRes;
          2'd3: out_d[31:0]   = colRes;
          default: out_d[127:96] = colRes;
        endcase
        // The counter parks at 3 when the block completes; only the IDLE
        // accept brings it back to 0.
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (bus.iReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers, all cleared by the asynchronous reset so an
  // interrupted block never surfaces as a valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      blk_q   <= 128'h0;
      key_q   <= 128'h0;
      last_q  <= 1'b0;
      out_q   <= 128'h0;
      rdyEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      last_q  <= last_d;
      out_q   <= out_d;
      rdyEn_q <= 1'b1;
    end
  end

  assign bus.oReady    = rdyEn_q && (state_q == IDLE);
  assign bus.oValid    = (state_q == DONE);
  assign bus.oBlockout = out_q;

  // The last column write always leaves BUSY.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BUSY && cnt_q == 2'd3) |=> (state_q == DONE));

  // A held result does not move while the consumer stalls.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !bus.iReady) |=> (state_q == DONE && $stable(out_q)));

endmodule

// File: tb/tb_en_colmix_keyadd_serial.sv
// ---------------------------------------------------------------------------
// tb_en_colmix_keyadd_serial
// Directed bench for en_colmix_keyadd_serial: a table of known blocks with
// hand-computed results, then hand-written backpressure, reset-mid-operation
// and input hold-off sequences.
// ---------------------------------------------------------------------------
module tb_en_colmix_keyadd_serial;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  en_colmix_keyadd_serial_if bus ();

  en_colmix_keyadd_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] block;
    logic [127:0] key;
    logic         last;
    logic [127:0] expected;
  } vec_t;

  vec_t vecs[6];

  localparam logic [127:0] BLK_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] RES_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  // Compare one value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for oReady, offer one block, and count edges from the
  // accept edge until oValid appears.
  task automatic applyStimulus(input logic [127:0] block, input logic [127:0] key,
                               input logic last, output logic [127:0] res,
                               output int lat);
    int waitCnt;
    waitCnt = 0;
    while (bus.oReady !== 1'b1 && waitCnt < 20) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (bus.oReady !== 1'b1) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL ready-wait: oReady never rose");
    end
    bus.iBlockIn   = block;
    bus.iKeyValue  = key;
    bus.iLastRound = last;
    bus.iValid     = 1'b1;
    @(posedge clk);
    #1;
    bus.iValid = 1'b0;
    lat = 0;
    while (bus.oValid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.oValid !== 1'b1) lat = -1;
    res = bus.oBlockout;
  endtask

  // Hand the result to the consumer and check the return to IDLE.
  task automatic releaseOutput(input string name, input logic [127:0] exp);
    bus.iReady = 1'b1;
    @(posedge clk);
    #1;
    bus.iReady = 1'b0;
    checkOutput({name, " oValid drop"}, {127'h0, bus.oValid}, 128'h0);
    checkOutput({name, " oReady back"}, {127'h0, bus.oReady}, 128'h1);
    checkOutput({name, " retained"}, bus.oBlockout, exp);
  endtask

  initial begin
    logic [127:0] res;
    int           lat;

    nCompared   = 0;
    nMismatched = 0;

    vecs[0] = '{"mix known", BLK_A, 128'h0, 1'b0, RES_A};
    vecs[1] = '{"mix plus key",
                128'hd4d4d4d5_2d26314c_00000000_00000000,
                128'hffffffff_00000000_00000000_ffffffff, 1'b0,
                128'h2a2a2829_4d7ebdf8_00000000_ffffffff};
    vecs[2] = '{"last key zero", BLK_A, 128'h0, 1'b1, BLK_A};
    vecs[3] = '{"last key ones", BLK_A, {128{1'b1}}, 1'b1, ~BLK_A};
    vecs[4] = '{"column order",
                128'hc6c6c6c6_01010101_db135345_f20a225c, 128'h0, 1'b0,
                128'hc6c6c6c6_01010101_8e4da1bc_9fdc589d};
    vecs[5] = '{"zero block key only", 128'h0,
                128'h00112233_44556677_8899aabb_ccddeeff, 1'b0,
                128'h00112233_44556677_8899aabb_ccddeeff};

    rst_n          = 1'b0;
    bus.iValid     = 1'b0;
    bus.iReady     = 1'b0;
    bus.iBlockIn   = 128'h0;
    bus.iKeyValue  = 128'h0;
    bus.iLastRound = 1'b0;

    // Reset values
    #2;
    checkOutput("reset oReady", {127'h0, bus.oReady}, 128'h0);
    checkOutput("reset oValid", {127'h0, bus.oValid}, 128'h0);
    checkOutput("reset oBlockout", bus.oBlockout, 128'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset oReady", {127'h0, bus.oReady}, 128'h1);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].block, vecs[i].key, vecs[i].last, res, lat);
      checkOutput({vecs[i].name, " data"}, res, vecs[i].expected);
      checkOutput({vecs[i].name, " latency"}, 128'(lat), 128'd4);
      releaseOutput(vecs[i].name, vecs[i].expected);
    end

    // Backpressure: stall five cycles and offer a stray block meanwhile
    applyStimulus(BLK_A, 128'h0, 1'b0, res, lat);
    checkOutput("bp data", res, RES_A);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.iBlockIn  = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
        bus.iKeyValue = {128{1'b1}};
        bus.iValid    = 1'b1;
      end else begin
        bus.iValid = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("bp oValid held", {127'h0, bus.oValid}, 128'h1);
      checkOutput("bp oReady low", {127'h0, bus.oReady}, 128'h0);
      checkOutput("bp oBlockout held", bus.oBlockout, RES_A);
    end
    bus.iValid = 1'b0;
    releaseOutput("bp", RES_A);
    @(posedge clk);
    #1;
    checkOutput("bp no stray start", {127'h0, bus.oValid}, 128'h0);
    checkOutput("bp still ready", {127'h0, bus.oReady}, 128'h1);

    // Reset in the middle of BUSY
    bus.iBlockIn   = BLK_A;
    bus.iKeyValue  = 128'h0;
    bus.iLastRound = 1'b0;
    bus.iValid     = 1'b1;
    @(posedge clk);
    #1;
    bus.iValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset oValid", {127'h0, bus.oValid}, 128'h0);
    checkOutput("midreset oBlockout", bus.oBlockout, 128'h0);
    checkOutput("midreset oReady", {127'h0, bus.oReady}, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(BLK_A, 128'h0, 1'b0, res, lat);
    checkOutput("after reset data", res, RES_A);
    checkOutput("after reset latency", 128'(lat), 128'd4);
    releaseOutput("after reset", RES_A);

    // Input hold-off: inputs change right after the first BUSY edge
    bus.iBlockIn   = BLK_A;
    bus.iKeyValue  = 128'h0;
    bus.iLastRound = 1'b0;
    bus.iValid     = 1'b1;
    @(posedge clk);
    #1;
    bus.iValid = 1'b0;
    @(posedge clk);
    #1;
    bus.iBlockIn   = ~BLK_A;
    bus.iKeyValue  = {128{1'b1}};
    bus.iLastRound = 1'b1;
    bus.iValid     = 1'b1;
    lat = 1;
    while (bus.oValid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.iValid = 1'b0;
    checkOutput("holdoff latency", 128'(lat), 128'd4);
    checkOutput("holdoff data", bus.oBlockout, RES_A);
    releaseOutput("holdoff", RES_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
